// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
package fnd_pkg;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}.
    localparam logic [7:0] SEG_0     = 8'hc0;
    localparam logic [7:0] SEG_1     = 8'hf9;
    localparam logic [7:0] SEG_2     = 8'ha4;
    localparam logic [7:0] SEG_3     = 8'hb0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hf8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hff;
    localparam logic [7:0] SEG_DASH  = 8'hbf;

    typedef enum logic [1:0] {
        CONV_IDLE   = 2'd0,
        CONV_SHIFT  = 2'd1,
        CONV_COMMIT = 2'd2
    } conv_state_t;

    // Width needed to hold values 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // BCD nibble to segment pattern; anything outside 0..9 shows blank.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Datapath-side load port plus board-side FND pins of the scan controller.
interface fnd_scan_controller_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14
);
    logic [DATA_W-1:0]     i_data;
    logic                  i_load;
    logic [NUM_DIGITS-1:0] i_dp;
    logic                  i_blank_lz;
    logic [NUM_DIGITS-1:0] i_blink_mask;
    logic                  o_busy;
    logic [NUM_DIGITS-1:0] fnd_com;
    logic [7:0]            fnd_data;

    modport master (
        output i_data, i_load, i_dp, i_blank_lz, i_blink_mask,
        input  o_busy, fnd_com, fnd_data
    );

    modport slave (
        input  i_data, i_load, i_dp, i_blank_lz, i_blink_mask,
        output o_busy, fnd_com, fnd_data
    );
endinterface

// File: rtl/fnd_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  CONV_IDLE    | waiting for load; captures data and clears the work register
//  CONV_SHIFT   | DATA_W cycles: adjust nibbles >=5 by +3, shift one bit in
//  CONV_COMMIT  | one cycle: done=1, result is stable for the display register
module fnd_bin2bcd
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       data,
    input  logic                    load,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow,
    output logic                    busy,
    output logic                    done
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = cnt_w(DATA_W);

    conv_state_t       state;
    conv_state_t       state_nxt;
    logic [DATA_W-1:0] bin_sr;
    logic [BCD_W-1:0]  work;
    logic [BCD_W-1:0]  work_adj;
    logic              work_ovf;
    logic [CNT_W-1:0]  bit_cnt;
    logic              shift_last;

    assign shift_last = (bit_cnt == '0);
    assign bcd        = work;
    assign overflow   = work_ovf;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= CONV_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; loads arriving outside IDLE are simply dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE:   if (load) state_nxt = CONV_SHIFT;
            CONV_SHIFT:  if (shift_last) state_nxt = CONV_COMMIT;
            CONV_COMMIT: state_nxt = CONV_IDLE;
            default:     state_nxt = CONV_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = (state != CONV_IDLE);
        done = (state == CONV_COMMIT);
    end

    // Add-3 correction on every nibble before the next doubling.
    always_comb begin
        work_adj = work;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (work[4*d +: 4] >= 4'd5) work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
        end
    end

    // Shift datapath; a 1 leaving the top nibble means the value has no room.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bin_sr   <= '0;
            work     <= '0;
            work_ovf <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                CONV_IDLE: begin
                    if (load) begin
                        bin_sr   <= data;
                        work     <= '0;
                        work_ovf <= 1'b0;
                        bit_cnt  <= CNT_W'(DATA_W - 1);
                    end
                end
                CONV_SHIFT: begin
                    work     <= {work_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
                    work_ovf <= work_ovf | work_adj[BCD_W-1];
                    bin_sr   <= {bin_sr[DATA_W-2:0], 1'b0};
                    bit_cnt  <= bit_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode FND driver: converts a loaded value to BCD and
// scans it out one digit per tick with dp, leading-zero blanking and blink.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int BLINK_HZ   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fnd_scan_controller_if.slave bus
);
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SCAN_W    = cnt_w(SCAN_DIV);
    localparam int BLINK_W   = cnt_w(BLINK_DIV);
    localparam int IDX_W     = cnt_w(NUM_DIGITS);
    localparam int BCD_W     = 4 * NUM_DIGITS;

    logic [BCD_W-1:0]      conv_bcd;
    logic                  conv_ovf;
    logic                  conv_done;
    logic [BCD_W-1:0]      disp_bcd;
    logic                  disp_ovf;
    logic [SCAN_W-1:0]     scan_cnt;
    logic                  scan_tick;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blink_tick;
    logic                  blink_phase;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  hi_zero;
    logic [7:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] com_nxt;

    fnd_bin2bcd #(
        .NUM_DIGITS (NUM_DIGITS),
        .DATA_W     (DATA_W)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .data     (bus.i_data),
        .load     (bus.i_load),
        .bcd      (conv_bcd),
        .overflow (conv_ovf),
        .busy     (bus.o_busy),
        .done     (conv_done)
    );

    assign scan_tick  = (scan_cnt == '0);
    assign blink_tick = (blink_cnt == '0);

    // Display register: old value stays up until the converter commits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else if (conv_done) begin
            disp_bcd <= conv_bcd;
            disp_ovf <= conv_ovf;
        end
    end

    // Scan and blink down-counters reload on terminal count; blink phase toggles there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            scan_cnt  <= scan_tick  ? SCAN_W'(SCAN_DIV - 1)   : scan_cnt - SCAN_W'(1);
            blink_cnt <= blink_tick ? BLINK_W'(BLINK_DIV - 1) : blink_cnt - BLINK_W'(1);
            if (blink_tick) blink_phase <= ~blink_phase;
        end
    end

    // Digit index advances per scan tick and wraps at the last digit.
    always_ff @(posedge clk) begin
        if (!rst)           idx <= '0;
        else if (scan_tick) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end

    // Select the current digit and apply blink > overflow > LZ blank > BCD priority.
    always_comb begin
        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        hi_zero   = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                cur_nib   = disp_bcd[4*d +: 4];
                cur_dp    = bus.i_dp[d];
                cur_blink = bus.i_blink_mask[d];
            end
            if ((IDX_W'(d) >= idx) && (disp_bcd[4*d +: 4] != 4'd0)) hi_zero = 1'b0;
        end

        if (cur_blink && blink_phase) begin
            seg_nxt = SEG_BLANK;
        end else begin
            if (disp_ovf)                                    seg_nxt = SEG_DASH;
            else if ((idx != '0) && bus.i_blank_lz && hi_zero) seg_nxt = SEG_BLANK;
            else                                             seg_nxt = seg_encode(cur_nib);
            seg_nxt[7] = ~cur_dp;
        end

        com_nxt = ~(NUM_DIGITS'(1) << idx);
    end

    // Common and segment pins change on the same tick edge so no digit ghosts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.fnd_com  <= '1;
            bus.fnd_data <= SEG_BLANK;
        end else if (scan_tick) begin
            bus.fnd_com  <= com_nxt;
            bus.fnd_data <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for the FND scan controller (4-digit and 3-digit instances).
module tb_fnd_scan_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fnd_scan_controller_if #(.NUM_DIGITS(4), .DATA_W(14)) bus4 ();
    fnd_scan_controller_if #(.NUM_DIGITS(3), .DATA_W(14)) bus3 ();

    fnd_scan_controller #(
        .NUM_DIGITS(4), .DATA_W(14), .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    fnd_scan_controller #(
        .NUM_DIGITS(3), .DATA_W(14), .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(5)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct packed {
        logic [3:0] com;
        logic [7:0] data;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed no scan update expected one within bound", tag);
    endtask

    task automatic push4(input logic [7:0] d0, d1, d2, d3);
        exp_q.push_back(frame_t'({4'b1110, d0}));
        exp_q.push_back(frame_t'({4'b1101, d1}));
        exp_q.push_back(frame_t'({4'b1011, d2}));
        exp_q.push_back(frame_t'({4'b0111, d3}));
    endtask

    // 3-digit commons padded with a leading 1 so they share the queue.
    task automatic push3(input logic [7:0] d0, d1, d2);
        exp_q.push_back(frame_t'({4'b1110, d0}));
        exp_q.push_back(frame_t'({4'b1101, d1}));
        exp_q.push_back(frame_t'({4'b1011, d2}));
    endtask

    task automatic sample(input bit use3, output logic [3:0] com, output logic [7:0] data);
        if (use3) begin
            com  = {1'b1, bus3.fnd_com};
            data = bus3.fnd_data;
        end else begin
            com  = bus4.fnd_com;
            data = bus4.fnd_data;
        end
    endtask

    task automatic wait_com(input bit use3, input logic [3:0] target, input bit want_eq, output bit ok);
        logic [3:0] c;
        logic [7:0] d;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            sample(use3, c, d);
            if ((c === target) == want_eq) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Pop expected digits in scan order, starting from a fresh refresh of digit 0.
    task automatic check_frames(input bit use3, input string tag);
        frame_t     f;
        bit         ok;
        logic [3:0] c;
        logic [7:0] d;
        int         i;
        i = 0;
        wait_com(use3, 4'b1110, 1'b0, ok);
        if (!ok) timeout({tag, "_align"});
        while (exp_q.size() > 0) begin
            f = exp_q.pop_front();
            wait_com(use3, f.com, 1'b1, ok);
            if (!ok) begin
                timeout($sformatf("%s[%0d]", tag, i));
            end else begin
                sample(use3, c, d);
                check($sformatf("%s[%0d]", tag, i), {20'd0, c, d}, {20'd0, f});
            end
            i++;
        end
    endtask

    task automatic load4(input logic [13:0] v);
        bus4.i_data = v;
        bus4.i_load = 1'b1;
        @(negedge clk);
        bus4.i_load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus4.o_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) timeout(tag);
    endtask

    initial begin
        int         busy_n;
        bit         ok;
        logic [3:0] c;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] prev;
        int         run;
        int         trans;

        bus4.i_data = '0; bus4.i_load = 1'b0; bus4.i_dp = '0; bus4.i_blank_lz = 1'b0; bus4.i_blink_mask = '0;
        bus3.i_data = '0; bus3.i_load = 1'b0; bus3.i_dp = '0; bus3.i_blank_lz = 1'b0; bus3.i_blink_mask = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_com", {28'd0, bus4.fnd_com}, 32'hf);
        check("rst_data", {24'd0, bus4.fnd_data}, 32'hff);
        check("rst_busy", {31'd0, bus4.o_busy}, 32'd0);
        check("rst_com3", {29'd0, bus3.fnd_com}, 32'h7);
        rst = 1'b1;
        @(negedge clk);
        check("first_tick_com", {28'd0, bus4.fnd_com}, 32'he);
        check("first_tick_data", {24'd0, bus4.fnd_data}, 32'hc0);

        // 1234: busy length, digit order, wrap back to digit 0
        load4(14'd1234);
        busy_n = 0;
        while (bus4.o_busy === 1'b1 && busy_n < 100) begin
            busy_n++;
            @(negedge clk);
        end
        check("busy_cycles", busy_n, 32'd15);
        push4(8'h99, 8'hb0, 8'ha4, 8'hf9);
        push4(8'h99, 8'hb0, 8'ha4, 8'hf9);
        check_frames(1'b0, "v1234");

        // 7 with and without leading-zero blanking
        bus4.i_blank_lz = 1'b1;
        load4(14'd7);
        wait_idle("idle7");
        push4(8'hf8, 8'hff, 8'hff, 8'hff);
        check_frames(1'b0, "v7_lz");
        bus4.i_blank_lz = 1'b0;
        push4(8'hf8, 8'hc0, 8'hc0, 8'hc0);
        check_frames(1'b0, "v7_nolz");

        // Interior zeros are never blanked
        bus4.i_blank_lz = 1'b1;
        load4(14'd1005);
        wait_idle("idle1005");
        push4(8'h92, 8'hc0, 8'hc0, 8'hf9);
        check_frames(1'b0, "v1005");

        // Overflow boundary
        load4(14'd10000);
        wait_idle("idle10000");
        push4(8'hbf, 8'hbf, 8'hbf, 8'hbf);
        check_frames(1'b0, "v10000");
        load4(14'd9999);
        wait_idle("idle9999");
        push4(8'h90, 8'h90, 8'h90, 8'h90);
        check_frames(1'b0, "v9999");

        // Load while busy is dropped
        bus4.i_blank_lz = 1'b0;
        load4(14'd42);
        @(negedge clk);
        check("busy_at_second_load", {31'd0, bus4.o_busy}, 32'd1);
        load4(14'd55);
        wait_idle("idle42");
        push4(8'ha4, 8'h99, 8'hc0, 8'hc0);
        check_frames(1'b0, "v42");

        // Reset in the middle of a conversion
        load4(14'd1234);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("busy_after_rst", {31'd0, bus4.o_busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("busy_stays_low", {31'd0, bus4.o_busy}, 32'd0);
        push4(8'hc0, 8'hc0, 8'hc0, 8'hc0);
        check_frames(1'b0, "rst_mid");

        // Decimal point on digit 1, blink on digit 0
        load4(14'd1234);
        wait_idle("idle_blink");
        bus4.i_dp = 4'b0010;
        bus4.i_blink_mask = 4'b0001;
        prev = 8'h00; run = 0; trans = 0;
        wait_com(1'b0, 4'b1110, 1'b0, ok);
        for (int k = 0; k < 30; k++) begin
            wait_com(1'b0, 4'b1110, 1'b1, ok);
            if (!ok) timeout("blink_d0");
            sample(1'b0, c, d0);
            wait_com(1'b0, 4'b1101, 1'b1, ok);
            if (!ok) timeout("blink_d1");
            sample(1'b0, c, d1);
            check("dp_digit1", {24'd0, d1}, 32'h30);
            check("blink_d0_value", {31'd0, (d0 == 8'h99) || (d0 == 8'hff)}, 32'd1);
            if (k == 0) begin
                prev = d0;
                run  = 1;
            end else if (d0 == prev) begin
                run++;
            end else begin
                if (trans > 0) check("blink_run_len", {31'd0, (run >= 2) && (run <= 3)}, 32'd1);
                trans++;
                prev = d0;
                run  = 1;
            end
        end
        check("blink_toggles", {31'd0, trans >= 8}, 32'd1);
        bus4.i_dp = '0;
        bus4.i_blink_mask = '0;

        // 3-digit instance: 1000 overflows, index wraps 2 -> 0
        bus3.i_data = 14'd1000;
        bus3.i_load = 1'b1;
        @(negedge clk);
        bus3.i_load = 1'b0;
        busy_n = 0;
        while (bus3.o_busy === 1'b1 && busy_n < 100) begin
            busy_n++;
            @(negedge clk);
        end
        check("busy_cycles3", busy_n, 32'd15);
        push3(8'hbf, 8'hbf, 8'hbf);
        push3(8'hbf, 8'hbf, 8'hbf);
        check_frames(1'b1, "n3_v1000");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
